ram_scanner: RTL and testbench

Read-side engine for the display image RAM: on a start pulse it walks the RAM from address 0 to DEPTH-1, one 54-bit line per word, and streams the image out one pixel per bit over a valid/ready interface toward the TFT driver. It drives the RAM read port (rd, address, one-cycle registered data) and prefetches the next line while the current line is shifting out, so a frame streams with no bubbles.

---
 rtl/display_pkg.sv | 18 +
 rtl/pixel_serializer.sv | 78 +++++++
 rtl/ram_scanner.sv | 180 ++++++++++++++++++
 tb/tb_ram_scanner.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared definitions for the display image RAM read-side path:
// geometry defaults and the scanner FSM state encoding.
package display_pkg;

    localparam int DATA_W_DEF = 54;    // pixels per RAM line
    localparam int ADDR_W_DEF = 12;    // RAM address width
    localparam int DEPTH_DEF  = 3200;  // lines per frame
    localparam int BIT_W      = 6;     // pixel-in-line counter width

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_STREAM = 3'd3,
        ST_DONE   = 3'd4
    } scan_state_t;

endpackage

// File: rtl/pixel_serializer.sv
// Line-to-pixel serializer: holds the line being shifted out (MSB first),
// a one-line prefetch buffer, the pixel-in-line counter and the
// valid/ready output stage with the start-of-line flag.
module pixel_serializer
    import display_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,     // first line of a frame, straight from RAM data
    input  logic              i_adv,      // last pixel of a line accepted, move to next line
    input  logic              i_clear,    // frame finished, drop valid
    input  logic              i_nbuf_we,  // prefetched line present on i_data
    input  logic              i_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_pix,
    output logic              o_valid,
    output logic              o_sol,
    output logic [BIT_W-1:0]  o_bit
);

    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_nbuf;
    logic              r_nbuf_valid;
    logic [BIT_W-1:0]  r_bit;
    logic              r_valid;
    logic              r_sol;
    logic              w_hs;

    assign w_hs = r_valid & i_ready;

    // Shift register, prefetch buffer and pixel counter; all state only moves on a handshake or a line load.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_shift      <= '0;
            r_nbuf       <= '0;
            r_nbuf_valid <= 1'b0;
            r_bit        <= '0;
            r_valid      <= 1'b0;
            r_sol        <= 1'b0;
        end else if (i_clear) begin
            r_shift      <= '0;
            r_nbuf       <= '0;
            r_nbuf_valid <= 1'b0;
            r_bit        <= '0;
            r_valid      <= 1'b0;
            r_sol        <= 1'b0;
        end else begin
            if (i_load) begin
                r_shift <= i_data;
                r_bit   <= '0;
                r_valid <= 1'b1;
                r_sol   <= 1'b1;
            end else if (i_adv) begin
                // An empty prefetch buffer would mean a starved line; blank it rather than replay stale pixels.
                r_shift      <= r_nbuf_valid ? r_nbuf : '0;
                r_nbuf_valid <= 1'b0;
                r_bit        <= '0;
                r_sol        <= 1'b1;
            end else if (w_hs) begin
                r_shift <= {r_shift[DATA_W-2:0], 1'b0};
                r_bit   <= r_bit + BIT_W'(1);
                r_sol   <= 1'b0;
            end
            if (i_nbuf_we) begin
                r_nbuf       <= i_data;
                r_nbuf_valid <= 1'b1;
            end
        end
    end

    assign o_pix   = r_shift[DATA_W-1];
    assign o_valid = r_valid;
    assign o_sol   = r_sol;
    assign o_bit   = r_bit;

endmodule

// File: rtl/ram_scanner.sv
// Read-side engine for the display image RAM: walks lines 0..DEPTH-1,
// prefetching line k+1 while line k shifts out, and streams one pixel per
// handshake toward the TFT driver with frame/line markers.
module ram_scanner
    import display_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_rd,
    output logic [ADDR_W-1:0] o_addr,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_pix,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_sol,
    output logic              o_sof,
    output logic              o_eof
);

    localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W + 1)'(DEPTH);

    scan_state_t       r_state;
    scan_state_t       w_state_nxt;
    logic [ADDR_W-1:0] r_word;
    logic [ADDR_W-1:0] w_word_nxt;
    logic              r_rd;
    logic              w_rd_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic              r_busy;
    logic              r_done;
    logic              r_sof;
    logic              w_sof_nxt;
    logic              r_eof;
    logic              w_eof_nxt;
    logic              r_pf_d;      // prefetch read issued last cycle, data on i_data now

    logic              w_load;
    logic              w_adv;
    logic              w_clear;
    logic              w_valid;
    logic              w_hs;
    logic [BIT_W-1:0]  w_bit;
    logic              w_last_bit;
    logic              w_last_word;
    logic [ADDR_W:0]   w_word_p2;

    assign w_hs        = w_valid & i_ready;
    assign w_last_bit  = (w_bit == BIT_W'(DATA_W - 1));
    assign w_last_word = (r_word == ADDR_W'(DEPTH - 1));
    assign w_word_p2   = {1'b0, r_word} + (ADDR_W + 1)'(2);

    // Next-state, RAM request and marker decode; registers below capture these so every output is a flop.
    always_comb begin
        w_state_nxt = r_state;
        w_word_nxt  = r_word;
        w_rd_nxt    = 1'b0;
        w_addr_nxt  = r_addr;
        w_sof_nxt   = r_sof;
        w_eof_nxt   = r_eof;
        w_load      = 1'b0;
        w_adv       = 1'b0;
        w_clear     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_FETCH;
                    w_rd_nxt    = 1'b1;
                    w_addr_nxt  = '0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FETCH: begin
                w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                // Line 0 arrives now; request line 1 for the first streaming cycle.
                w_state_nxt = ST_STREAM;
                w_load      = 1'b1;
                w_word_nxt  = '0;
                w_rd_nxt    = 1'b1;
                w_addr_nxt  = ADDR_W'(1);
                w_sof_nxt   = 1'b1;
                w_eof_nxt   = 1'b0;
            end
            ST_STREAM: begin
                if (w_hs) begin
                    w_sof_nxt = 1'b0;
                    if (w_last_bit) begin
                        w_eof_nxt = 1'b0;
                        if (w_last_word) begin
                            w_state_nxt = ST_DONE;
                            w_clear     = 1'b1;
                        end else begin
                            // Move to line k+1 and immediately prefetch line k+2 if it exists.
                            w_adv      = 1'b1;
                            w_word_nxt = r_word + ADDR_W'(1);
                            if (w_word_p2 < L_DEPTH) begin
                                w_rd_nxt   = 1'b1;
                                w_addr_nxt = w_word_p2[ADDR_W-1:0];
                            end else begin
                                w_rd_nxt = 1'b0;
                            end
                        end
                    end else begin
                        w_eof_nxt = w_last_word & (w_bit == BIT_W'(DATA_W - 2));
                    end
                end else begin
                    w_state_nxt = ST_STREAM;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state, word counter, RAM port and frame-level output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_word  <= '0;
            r_rd    <= 1'b0;
            r_addr  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sof   <= 1'b0;
            r_eof   <= 1'b0;
            r_pf_d  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_word  <= w_word_nxt;
            r_rd    <= w_rd_nxt;
            r_addr  <= w_addr_nxt;
            r_busy  <= (w_state_nxt == ST_FETCH) || (w_state_nxt == ST_LOAD) ||
                       (w_state_nxt == ST_STREAM);
            r_done  <= (w_state_nxt == ST_DONE);
            r_sof   <= w_sof_nxt;
            r_eof   <= w_eof_nxt;
            r_pf_d  <= r_rd && (r_state == ST_STREAM);
        end
    end

    pixel_serializer #(
        .DATA_W (DATA_W)
    ) u_ser (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_load    (w_load),
        .i_adv     (w_adv),
        .i_clear   (w_clear),
        .i_nbuf_we (r_pf_d),
        .i_ready   (i_ready),
        .i_data    (i_data),
        .o_pix     (o_pix),
        .o_valid   (w_valid),
        .o_sol     (o_sol),
        .o_bit     (w_bit)
    );

    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_rd    = r_rd;
    assign o_addr  = r_addr;
    assign o_valid = w_valid;
    assign o_sof   = r_sof;
    assign o_eof   = r_eof;

endmodule

// File: tb/tb_ram_scanner.sv
// Directed bench for ram_scanner with a 4-line frame: table of RAM images
// and ready modes, plus hand sequences for latency, reset, ignored start
// and back-to-back frames.
module tb_ram_scanner;

    localparam int DW    = 54;
    localparam int AW    = 12;
    localparam int DP    = 4;
    localparam int FRAME = DW * DP;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_start;
    logic          i_ready;
    logic [DW-1:0] i_data = '0;
    logic          o_busy, o_done, o_rd, o_valid, o_pix, o_sol, o_sof, o_eof;
    logic [AW-1:0] o_addr;

    logic [DW-1:0] ram [DP];

    int n_cmp = 0;
    int n_err = 0;

    ram_scanner #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (i_start),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_rd    (o_rd),
        .o_addr  (o_addr),
        .i_data  (i_data),
        .o_pix   (o_pix),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_sol   (o_sol),
        .o_sof   (o_sof),
        .o_eof   (o_eof)
    );

    always #5 i_clk = ~i_clk;

    // RAM model: registered read, data valid the cycle after o_rd
    always @(posedge i_clk) begin
        if (o_rd) i_data <= ram[o_addr[1:0]];
    end

    // ---------------- monitor (samples on falling edge) ----------------
    int cyc = 0, n_pix, n_ones, n_rd, n_done, sol_err, sof_err, eof_err;
    int stall_err, gap_err, last_hs_cyc, done_cyc, first_done_cyc;
    bit pix_q [1024];
    int rd_addr [16];
    int rd_cyc [16];
    int clr_req = 0;

    initial begin : monitor
        int  clr_seen;
        int  fp;
        logic p_valid, p_ready, p_pix, p_sol, p_sof, p_eof;
        clr_seen = 0;
        p_valid = 1'b0; p_ready = 1'b0; p_pix = 1'b0; p_sol = 1'b0; p_sof = 1'b0; p_eof = 1'b0;
        forever begin
            @(negedge i_clk);
            if (clr_req != clr_seen) begin
                clr_seen = clr_req;
                n_pix = 0; n_ones = 0; n_rd = 0; n_done = 0;
                sol_err = 0; sof_err = 0; eof_err = 0; stall_err = 0; gap_err = 0;
                last_hs_cyc = -100; done_cyc = -100; first_done_cyc = -100;
                p_valid = 1'b0;
            end
            cyc++;
            if (o_rd) begin
                if (n_rd < 16) begin
                    rd_addr[n_rd] = int'(o_addr);
                    rd_cyc[n_rd]  = cyc;
                end
                n_rd++;
            end
            if (p_valid && !p_ready) begin
                if (!o_valid || o_pix != p_pix || o_sol != p_sol || o_sof != p_sof || o_eof != p_eof)
                    stall_err++;
            end
            if (!o_valid && n_pix > 0 && (n_pix % FRAME) != 0) gap_err++;
            if (o_valid && i_ready) begin
                fp = n_pix % FRAME;
                if (n_pix < 1024) pix_q[n_pix] = o_pix;
                if (o_sol != ((fp % DW) == 0)) sol_err++;
                if (o_sof != (fp == 0)) sof_err++;
                if (o_eof != (fp == FRAME - 1)) eof_err++;
                n_ones += int'(o_pix);
                last_hs_cyc = cyc;
                n_pix++;
            end
            if (o_done) begin
                if (n_done == 0) first_done_cyc = cyc;
                n_done++;
                done_cyc = cyc;
            end
            p_valid = o_valid; p_ready = i_ready; p_pix = o_pix;
            p_sol = o_sol; p_sof = o_sof; p_eof = o_eof;
        end
    end

    // ---------------- helpers ----------------
    typedef struct {
        logic [3:0][DW-1:0] lines;
        bit                 rnd;       // 1: i_ready random 50%
        int                 exp_ones;  // hand-counted ones in the frame
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [DW-1:0] l0, input logic [DW-1:0] l1,
                           input logic [DW-1:0] l2, input logic [DW-1:0] l3,
                           input bit rnd, input int ones);
        vecs[i].lines[0] = l0;
        vecs[i].lines[1] = l1;
        vecs[i].lines[2] = l2;
        vecs[i].lines[3] = l3;
        vecs[i].rnd      = rnd;
        vecs[i].exp_ones = ones;
    endtask

    task automatic load_ram(input int i);
        for (int w = 0; w < DP; w++) ram[w] = vecs[i].lines[w];
    endtask

    task automatic clear_mon();
        clr_req++;
        @(negedge i_clk);
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, "_ctl"}, longint'({o_busy, o_done, o_rd, o_valid, o_pix, o_sol, o_sof, o_eof}), 0);
        chk({name, "_addr"}, longint'(o_addr), 0);
    endtask

    function automatic int pix_seq_errors(input int npix);
        int e = 0;
        logic [DW-1:0] line;
        for (int n = 0; n < npix && n < 1024; n++) begin
            line = ram[(n % FRAME) / DW];
            if (pix_q[n] != line[DW - 1 - (n % DW)]) e++;
        end
        return e;
    endfunction

    task automatic run_frame(input int i);
        int t;
        int aerr;
        load_ram(i);
        clear_mon();
        i_start = 1'b1;
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        t = 0;
        while (n_done == 0 && t < 3000) begin
            i_ready = vecs[i].rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge i_clk); #1;
            t++;
        end
        i_ready = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        chk($sformatf("v%0d_done_cnt", i), n_done, 1);
        chk($sformatf("v%0d_pix_cnt", i), n_pix, FRAME);
        chk($sformatf("v%0d_ones", i), n_ones, vecs[i].exp_ones);
        chk($sformatf("v%0d_pix_seq_err", i), pix_seq_errors(n_pix), 0);
        chk($sformatf("v%0d_sol_err", i), sol_err, 0);
        chk($sformatf("v%0d_sof_err", i), sof_err, 0);
        chk($sformatf("v%0d_eof_err", i), eof_err, 0);
        chk($sformatf("v%0d_stall_err", i), stall_err, 0);
        chk($sformatf("v%0d_gap_err", i), gap_err, 0);
        chk($sformatf("v%0d_rd_cnt", i), n_rd, DP);
        aerr = 0;
        for (int k = 0; k < DP && k < n_rd; k++) if (rd_addr[k] != k) aerr++;
        chk($sformatf("v%0d_rd_addr_err", i), aerr, 0);
        chk($sformatf("v%0d_done_lat", i), done_cyc - last_hs_cyc, 1);
        chk($sformatf("v%0d_busy_after", i), longint'(o_busy), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        int t;
        int seen;
        logic busy_before;

        set_vec(0, 54'h2AAAAAAAAAAAAA, 54'h2AAAAAAAAAAAAA, 54'h2AAAAAAAAAAAAA, 54'h2AAAAAAAAAAAAA, 1'b0, 108);
        set_vec(1, 54'h2AAAAAAAAAAAAA, 54'h2AAAAAAAAAAAAA, 54'h2AAAAAAAAAAAAA, 54'h2AAAAAAAAAAAAA, 1'b1, 108);
        set_vec(2, 54'h3FFFFFFFFFFFFF, 54'h0, 54'h3FFFFFFFFFFFFF, 54'h0, 1'b0, 108);
        set_vec(3, 54'h1, 54'h0, 54'h0, 54'h0, 1'b1, 1);
        set_vec(4, 54'h20000000000000, 54'h0, 54'h0, 54'h3FFFFFFFFFFFFF, 1'b1, 55);

        i_rst = 1'b1; i_start = 1'b0; i_ready = 1'b0;
        load_ram(0);
        repeat (2) @(posedge i_clk);
        #1;
        chk_idle_outputs("reset");
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        chk_idle_outputs("idle");

        // table-driven frames
        for (int i = 0; i < 5; i++) run_frame(i);

        // start-to-first-pixel latency
        load_ram(0);
        clear_mon();
        i_ready = 1'b1;
        i_start = 1'b1;
        @(posedge i_clk); #1;           // E0
        i_start = 1'b0;
        chk("lat_e0_rd", longint'(o_rd), 1);
        chk("lat_e0_addr", longint'(o_addr), 0);
        chk("lat_e0_busy", longint'(o_busy), 1);
        chk("lat_e0_valid", longint'(o_valid), 0);
        @(posedge i_clk); #1;           // E1
        chk("lat_e1_rd", longint'(o_rd), 0);
        chk("lat_e1_valid", longint'(o_valid), 0);
        @(posedge i_clk); #1;           // E2
        chk("lat_e2_valid", longint'(o_valid), 1);
        chk("lat_e2_sof", longint'(o_sof), 1);
        chk("lat_e2_sol", longint'(o_sol), 1);
        chk("lat_e2_pix", longint'(o_pix), 1);
        chk("lat_e2_rd", longint'(o_rd), 1);
        chk("lat_e2_addr", longint'(o_addr), 1);
        t = 0;
        while (n_done == 0 && t < 1000) begin @(posedge i_clk); #1; t++; end
        chk("lat_frame_done", n_done, 1);

        // asynchronous reset in the middle of a frame
        load_ram(2);
        clear_mon();
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        t = 0;
        while (n_pix < 60 && t < 500) begin @(posedge i_clk); #1; t++; end
        busy_before = o_busy;
        #2;
        i_rst = 1'b1;
        #1;
        chk("rst_mid_busy_before", longint'(busy_before), 1);
        chk_idle_outputs("rst_mid");
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        repeat (5) @(posedge i_clk);
        #1;
        chk("rst_mid_no_done", n_done, 0);
        chk("rst_mid_idle_busy", longint'(o_busy), 0);
        run_frame(2);                   // restart from line 0 with o_sof

        // i_start pulses during STREAM and DONE are ignored
        load_ram(0);
        clear_mon();
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        t = 0;
        while (n_pix < 100 && t < 500) begin @(posedge i_clk); #1; t++; end
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        t = 0;
        while (o_done == 1'b0 && t < 500) begin @(posedge i_clk); #1; t++; end
        i_start = 1'b1;                 // asserted while in DONE
        @(posedge i_clk); #1;
        i_start = 1'b0;
        repeat (6) @(posedge i_clk);
        #1;
        chk("ign_done_cnt", n_done, 1);
        chk("ign_rd_cnt", n_rd, DP);
        chk("ign_pix_cnt", n_pix, FRAME);
        chk("ign_busy", longint'(o_busy), 0);

        // i_start held high: two back-to-back frames
        load_ram(4);
        clear_mon();
        i_start = 1'b1;
        seen = 0;
        t = 0;
        while (seen < 2 && t < 2000) begin
            @(posedge i_clk); #1;
            if (o_done) seen++;
            t++;
        end
        i_start = 1'b0;
        repeat (5) @(posedge i_clk);
        #1;
        chk("b2b_done_cnt", n_done, 2);
        chk("b2b_rd_cnt", n_rd, 2 * DP);
        chk("b2b_pix_cnt", n_pix, 2 * FRAME);
        chk("b2b_pix_seq_err", pix_seq_errors(n_pix), 0);
        chk("b2b_sof_err", sof_err, 0);
        chk("b2b_eof_err", eof_err, 0);
        chk("b2b_restart_gap", rd_cyc[DP] - first_done_cyc, 2);
        chk("b2b_restart_addr", rd_addr[DP], 0);
        chk("b2b_busy", longint'(o_busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
